// File: rtl/tx_frame_modulator_pkg.sv
// Shared definitions for the ISO/IEC 14443-2 Type A PICC transmit path.
//
// Contents:
//   tx_state_t         - transmit FSM state encoding
//   BIT_TICKS_LOG2_DEF - default log2 of the bit period in carrier clocks (fc/128)
//   SUB_HALF_LOG2_DEF  - default log2 of the subcarrier half-period (fc/16)
//   modulated()        - Manchester + subcarrier drive level for one tick
package tx_frame_modulator_pkg;

    localparam int BIT_TICKS_LOG2_DEF = 7;
    localparam int SUB_HALF_LOG2_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SOF,
        ST_DATA,
        ST_EOF
    } tx_state_t;

    // A logic one modulates the first half of its bit period and a logic
    // zero the second half. Inside the modulated half the subcarrier is
    // high whenever its phase bit is low, so every burst starts high.
    function automatic logic modulated(input logic bitVal,
                                       input logic firstHalf,
                                       input logic subPhase);
        return (bitVal ? firstHalf : !firstHalf) && !subPhase;
    endfunction

endpackage

// File: rtl/tx_frame_modulator_if.sv
// Bit-stream handshake between the framing/CRC/parity stage and the
// transmit modulator.
//
// Signals:
//   in_valid - upstream has a bit available
//   in_data  - bit value
//   in_last  - bit is the final data bit of the frame
//   in_ready - single-cycle pulse from the modulator; the bit is consumed
//              on the clock edge where in_ready and in_valid are both high
//
// Modports: master = bit source, slave = modulator.
interface tx_frame_modulator_if;

    logic in_valid;
    logic in_data;
    logic in_last;
    logic in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/tx_frame_modulator_bit_timer.sv
// Tick counter that paces one bit period of the transmit modulator.
//
// Ports:
//   clk, rst      - carrier clock, synchronous active-high reset
//   clear_i       - force the count to zero on the next edge
//   enable_i      - advance the count by one (wraps at the end of a bit)
//   bit_end_o     - last tick of the current bit period
//   first_half_o  - tick lies in the first half of the bit period
//   sub_phase_o   - subcarrier phase bit (low = subcarrier high)
module tx_bit_timer #(
    parameter int BIT_TICKS_LOG2 = 7,
    parameter int SUB_HALF_LOG2  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_end_o,
    output logic first_half_o,
    output logic sub_phase_o
);

    localparam logic [BIT_TICKS_LOG2-1:0] CntOne = 1;

    logic [BIT_TICKS_LOG2-1:0] cnt_q;

    // Free-running within a frame: the count wraps naturally from the last
    // tick back to zero, so consecutive bits follow each other with no gap.
    // Clear has priority so the alignment cycle always starts SOF at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    // The bit-period and subcarrier are both powers of two, so every
    // timing event is just a bit of the counter.
    assign bit_end_o    = &cnt_q;
    assign first_half_o = !cnt_q[BIT_TICKS_LOG2-1];
    assign sub_phase_o  = cnt_q[SUB_HALF_LOG2];

endmodule

// File: rtl/tx_frame_modulator.sv
// PICC reply transmitter: on an fdt trigger it sends SOF, the data bits
// pulled from upstream, then EOF as ISO/IEC 14443-2 Type A 106 kbit/s
// Manchester-coded, subcarrier-modulated load modulation.
//
// Ports:
//   clk, rst        - carrier clock (fc), synchronous active-high reset
//   fdt_trigger_i   - single-cycle pulse marking the frame delay time
//   bitIf           - bit handshake (slave side): in_valid/in_data/in_last
//                     in, in_ready out (combinational pulse)
//   lm_out_o        - load-modulation drive, high = modulate
//   tx_busy_o       - frame in progress, SOF through EOF
//   tx_done_o       - single-cycle pulse after EOF completes
//   tx_underflow_o  - single-cycle pulse when a bit was needed but absent
module tx_frame_modulator
    import tx_frame_modulator_pkg::*;
#(
    parameter int BIT_TICKS_LOG2 = BIT_TICKS_LOG2_DEF,
    parameter int SUB_HALF_LOG2  = SUB_HALF_LOG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fdt_trigger_i,
    tx_frame_modulator_if.slave  bitIf,
    output logic                 lm_out_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o,
    output logic                 tx_underflow_o
);

    tx_state_t state_q, state_d;
    logic      curBit_q, curBit_d;
    logic      curLast_q, curLast_d;
    logic      lm_q, lm_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      under_q, under_d;

    logic      bitEnd;
    logic      firstHalf;
    logic      subPhase;
    logic      wantBit;

    tx_bit_timer #(
        .BIT_TICKS_LOG2 (BIT_TICKS_LOG2),
        .SUB_HALF_LOG2  (SUB_HALF_LOG2)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (state_q == ST_START),
        .enable_i     ((state_q == ST_SOF) || (state_q == ST_DATA) || (state_q == ST_EOF)),
        .bit_end_o    (bitEnd),
        .first_half_o (firstHalf),
        .sub_phase_o  (subPhase)
    );

    // The next bit is requested on the last tick of SOF and of every data
    // bit except the one flagged last. This is the only combinational
    // output so upstream sees the request in the same cycle it is consumed.
    assign wantBit        = bitEnd && ((state_q == ST_SOF) ||
                                       ((state_q == ST_DATA) && !curLast_q));
    assign bitIf.in_ready = wantBit;

    // Next-state and next-output logic. Every output is computed from the
    // current state and tick, then registered, so the whole output set
    // trails the state by exactly one cycle. That one-cycle lag together
    // with the START alignment cycle is what places the first modulation
    // edge two clocks after the trigger edge.
    always_comb begin
        state_d   = state_q;
        curBit_d  = curBit_q;
        curLast_d = curLast_q;
        lm_d      = 1'b0;
        busy_d    = (state_q != ST_IDLE);
        done_d    = 1'b0;
        under_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A trigger without a bit waiting means there is nothing
                // to reply with, so it is dropped silently.
                if (fdt_trigger_i && bitIf.in_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_SOF;
            end
            ST_SOF: begin
                lm_d = modulated(1'b1, firstHalf, subPhase);
            end
            ST_DATA: begin
                lm_d = modulated(curBit_q, firstHalf, subPhase);
                if (bitEnd && curLast_q) begin
                    state_d = ST_EOF;
                end
            end
            ST_EOF: begin
                if (bitEnd) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An absent bit still lets the current bit finish; the frame is
        // then closed with a normal EOF so the reader sees a valid end.
        if (wantBit) begin
            if (bitIf.in_valid) begin
                curBit_d  = bitIf.in_data;
                curLast_d = bitIf.in_last;
                state_d   = ST_DATA;
            end else begin
                under_d = 1'b1;
                state_d = ST_EOF;
            end
        end
    end

    // Single state/output register bank. Reset aborts any frame in flight
    // and, because tx_done is only set from the EOF tail, no done pulse
    // escapes for an aborted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            curBit_q  <= 1'b0;
            curLast_q <= 1'b0;
            lm_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            curBit_q  <= curBit_d;
            curLast_q <= curLast_d;
            lm_q      <= lm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            under_q   <= under_d;
        end
    end

    assign lm_out_o       = lm_q;
    assign tx_busy_o      = busy_q;
    assign tx_done_o      = done_q;
    assign tx_underflow_o = under_q;

endmodule

// File: tb/tb_tx_frame_modulator.sv
// Self-checking bench for tx_frame_modulator. A frame-level reference
// model derives the expected waveform from the bit list: symbol p/128 of
// the frame (SOF = 1, then data) is on air starting two clocks after the
// trigger edge, and each output is compared cycle by cycle.
module tb_tx_frame_modulator;

    localparam int MaxT = 3100;

    logic clk = 1'b0;
    logic rst;
    logic fdt;
    logic lm;
    logic busy;
    logic done;
    logic under;

    int checks = 0;
    int passes = 0;
    int acceptCnt;

    logic       bitsV [0:7];
    logic [4:0] obsV  [0:MaxT-1];
    logic [4:0] expV  [0:MaxT-1];

    tx_frame_modulator_if ifc ();

    tx_frame_modulator dut (
        .clk            (clk),
        .rst            (rst),
        .fdt_trigger_i  (fdt),
        .bitIf          (ifc.slave),
        .lm_out_o       (lm),
        .tx_busy_o      (busy),
        .tx_done_o      (done),
        .tx_underflow_o (under)
    );

    always #5 clk = ~clk;

    // Plays the upstream bit source and records {lm, busy, done, underflow,
    // in_ready} at the falling edge after each rising edge. t = 0 is the
    // capture right after the trigger edge k, so obsV[t] shows edge k+t.
    task automatic applyStimulus(input int nData, input int nAvail, input int L,
                                 input int retrigT, input int rstT);
        int idx;
        bit pending;
        idx       = 0;
        pending   = 1'b0;
        acceptCnt = 0;
        ifc.in_valid = (nAvail > 0);
        ifc.in_data  = bitsV[0];
        ifc.in_last  = (nData == 1);
        @(negedge clk);
        fdt = 1'b1;
        for (int t = 0; t < L; t++) begin
            @(negedge clk);
            if (t == 0) fdt = 1'b0;
            obsV[t] = {lm, busy, done, under, ifc.in_ready};
            if (pending) begin
                idx++;
                pending      = 1'b0;
                ifc.in_valid = (idx < nAvail);
                ifc.in_data  = bitsV[idx % 8];
                ifc.in_last  = (idx == nData - 1);
            end
            if (ifc.in_ready && ifc.in_valid) begin
                pending = 1'b1;
                acceptCnt++;
            end
            if (t == retrigT)     fdt = 1'b1;
            if (t == retrigT + 1) fdt = 1'b0;
            if (t == rstT)        rst = 1'b1;
            if (t == rstT + 5)    rst = 1'b0;
        end
        ifc.in_valid = 1'b0;
        fdt          = 1'b0;
        rst          = 1'b0;
    endtask

    // Frame-level reference: m data bits go on air (fewer than nData when
    // upstream runs dry), then a 128-cycle EOF.
    task automatic buildModel(input int nData, input int nAvail, input int L);
        int   m;
        bit   uf;
        bit   act;
        int   p;
        int   ph;
        logic sym;
        logic lmE;
        uf  = (nAvail < nData);
        m   = uf ? nAvail : nData;
        act = (nAvail > 0);
        for (int t = 0; t < L; t++) begin
            p   = t - 2;
            lmE = 1'b0;
            if (act && p >= 0 && p / 128 <= m) begin
                sym = (p / 128 == 0) ? 1'b1 : bitsV[p / 128 - 1];
                ph  = p % 128;
                lmE = (sym ? (ph < 64) : (ph >= 64)) && ((ph / 8) % 2 == 0);
            end
            expV[t] = {lmE,
                       act && t >= 1 && t <= 1 + 128 * (m + 2),
                       act && t == 1 + 128 * (m + 2),
                       act && uf && t == 1 + 128 * (m + 1),
                       act && t > 0 && t % 128 == 0 && t / 128 <= (uf ? m + 1 : m)};
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({lm, busy, done, under, ifc.in_ready} !== 5'b0)
            $display("[TB] FAIL reset_state: got %b expected 00000", {lm, busy, done, under, ifc.in_ready});
        else passes++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) bitsV[i] = 1'($urandom);
        applyStimulus(4, 4, 1000, -1, 300);
        checks++;
        if (obsV[300][3] !== 1'b1)
            $display("[TB] FAIL reset_busy_before: got %b expected 1", obsV[300][3]);
        else passes++;
        checks++;
        if (obsV[301] !== 5'b0)
            $display("[TB] FAIL reset_midframe: got %b expected 00000", obsV[301]);
        else passes++;
        bad = 0;
        for (int t = 301; t < 1000; t++) if (obsV[t] !== 5'b0) bad++;
        checks++;
        if (bad != 0)
            $display("[TB] FAIL reset_quiet_after: %0d active cycles, expected 0", bad);
        else passes++;
    endtask

    task automatic test_no_valid();
        int busyHi;
        int lmHi;
        applyStimulus(3, 0, 3000, -1, -1);
        busyHi = 0;
        lmHi   = 0;
        for (int t = 0; t < 3000; t++) begin
            if (obsV[t][3] !== 1'b0) busyHi++;
            if (obsV[t][4] !== 1'b0) lmHi++;
        end
        checks++;
        if (busyHi != 0) $display("[TB] FAIL novalid_busy: %0d busy cycles, expected 0", busyHi);
        else passes++;
        checks++;
        if (lmHi != 0) $display("[TB] FAIL novalid_lm: %0d lm cycles, expected 0", lmHi);
        else passes++;
    endtask

    task automatic test_fixed_frame();
        int bad;
        int firstT;
        bitsV[0] = 1'b1; bitsV[1] = 1'b0; bitsV[2] = 1'b1;
        buildModel(3, 3, 700);
        applyStimulus(3, 3, 700, -1, -1);
        bad = 0; firstT = 0;
        for (int t = 0; t < 700; t++)
            if (obsV[t] !== expV[t]) begin if (bad == 0) firstT = t; bad++; end
        checks++;
        if (bad != 0)
            $display("[TB] FAIL fixed_wave: %0d bad cycles, first t=%0d got %b expected %b", bad, firstT, obsV[firstT], expV[firstT]);
        else passes++;
        checks++;
        if (obsV[1][4] !== 1'b0 || obsV[2][4] !== 1'b1)
            $display("[TB] FAIL fixed_first_edge: got %b%b expected 01", obsV[1][4], obsV[2][4]);
        else passes++;
        checks++;
        if (obsV[641][2] !== 1'b1 || obsV[642][3] !== 1'b0)
            $display("[TB] FAIL fixed_done_time: done=%b busy_after=%b expected 1 0", obsV[641][2], obsV[642][3]);
        else passes++;
        checks++;
        if (acceptCnt !== 3) $display("[TB] FAIL fixed_accepts: got %0d expected 3", acceptCnt);
        else passes++;
    endtask

    task automatic test_single_zero();
        int bad;
        int firstT;
        int eofHi;
        bitsV[0] = 1'b0;
        buildModel(1, 1, 450);
        applyStimulus(1, 1, 450, -1, -1);
        bad = 0; firstT = 0;
        for (int t = 0; t < 450; t++)
            if (obsV[t] !== expV[t]) begin if (bad == 0) firstT = t; bad++; end
        checks++;
        if (bad != 0)
            $display("[TB] FAIL single_wave: %0d bad cycles, first t=%0d got %b expected %b", bad, firstT, obsV[firstT], expV[firstT]);
        else passes++;
        eofHi = 0;
        for (int t = 258; t < 386; t++) if (obsV[t][4] !== 1'b0) eofHi++;
        checks++;
        if (eofHi != 0 || obsV[385][2] !== 1'b1)
            $display("[TB] FAIL single_eof: lm high %0d cycles done=%b expected 0 cycles done=1", eofHi, obsV[385][2]);
        else passes++;
    endtask

    task automatic test_underflow();
        int bad;
        int firstT;
        for (int i = 0; i < 8; i++) bitsV[i] = 1'($urandom);
        buildModel(3, 1, 600);
        applyStimulus(3, 1, 600, -1, -1);
        bad = 0; firstT = 0;
        for (int t = 0; t < 600; t++)
            if (obsV[t] !== expV[t]) begin if (bad == 0) firstT = t; bad++; end
        checks++;
        if (bad != 0)
            $display("[TB] FAIL underflow_wave: %0d bad cycles, first t=%0d got %b expected %b", bad, firstT, obsV[firstT], expV[firstT]);
        else passes++;
        checks++;
        if (obsV[257][1] !== 1'b1 || obsV[385][2] !== 1'b1)
            $display("[TB] FAIL underflow_pulses: under=%b done=%b expected 1 1", obsV[257][1], obsV[385][2]);
        else passes++;
    endtask

    task automatic test_retrigger();
        int bad;
        int firstT;
        int n;
        n = 2 + int'($urandom_range(2));
        for (int i = 0; i < 8; i++) bitsV[i] = 1'($urandom);
        buildModel(n, n, 128 * 6 + 10);
        applyStimulus(n, n, 128 * 6 + 10, 300, -1);
        bad = 0; firstT = 0;
        for (int t = 0; t < 128 * 6 + 10; t++)
            if (obsV[t] !== expV[t]) begin if (bad == 0) firstT = t; bad++; end
        checks++;
        if (bad != 0)
            $display("[TB] FAIL retrigger_wave: %0d bad cycles, first t=%0d got %b expected %b", bad, firstT, obsV[firstT], expV[firstT]);
        else passes++;
    endtask

    task automatic test_random();
        int bad;
        int firstT;
        int n;
        int avail;
        int len;
        for (int it = 0; it < 5; it++) begin
            n = 1 + int'($urandom_range(4));
            avail = n;
            if (n > 1 && $urandom_range(3) == 0) avail = 1 + int'($urandom_range(n - 2));
            for (int i = 0; i < 8; i++) bitsV[i] = 1'($urandom);
            len = 1 + 128 * (n + 2) + 20;
            buildModel(n, avail, len);
            applyStimulus(n, avail, len, -1, -1);
            bad = 0; firstT = 0;
            for (int t = 0; t < len; t++)
                if (obsV[t] !== expV[t]) begin if (bad == 0) firstT = t; bad++; end
            checks++;
            if (bad != 0)
                $display("[TB] FAIL random_wave_%0d: n=%0d avail=%0d %0d bad cycles, first t=%0d got %b expected %b", it, n, avail, bad, firstT, obsV[firstT], expV[firstT]);
            else passes++;
            repeat (int'($urandom_range(5))) @(negedge clk);
        end
    endtask

    initial begin
        rst          = 1'b0;
        fdt          = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 1'b0;
        ifc.in_last  = 1'b0;
        test_reset();
        test_no_valid();
        test_fixed_frame();
        test_single_zero();
        test_underflow();
        test_retrigger();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
